// File: rtl/bepu_bus_scheduler_pkg.sv
// Shared definitions for the back-end peripheral bus scheduler.
//   - issue FSM state encoding
//   - device index constants for the addr[DEV_LSB+3:DEV_LSB] field
//   - default position of the device index field
package bepu_bus_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWaitVga = 2'd2
  } state_e;

  localparam int unsigned DEV_LED = 0;
  localparam int unsigned DEV_SEG = 1;
  localparam int unsigned DEV_VGA = 2;

  localparam int unsigned DEV_LSB_DEFAULT = 12;

endpackage

// File: rtl/bepu_write_fifo.sv
// Synchronous FIFO holding accepted bus writes.
// Ports:
//   clk, rst       clock and asynchronous active-low reset
//   push, wdata    enqueue request and entry (ignored when full without a pop)
//   pop            dequeue request (ignored when empty)
//   rdata          head entry, valid when !empty
//   full, empty    status flags
module bepu_write_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    do_pop  = pop && !empty;
    // A pop frees the slot this push needs, so push-while-full is legal with a pop.
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    rdata   = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/bepu_bus_scheduler.sv
// Back-end peripheral bus scheduler.
// Two write masters (m0 = CPU store path, m1 = debug/boot loader) are round-robin
// arbitrated into a write FIFO; the head entry is decoded and issued as a one-cycle
// bus_w strobe with a one-hot device select. VGA writes wait while vga_busy is high.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   m{0,1}_valid/addr/data/ready  master write request channels (ready = pushed this edge)
//   vga_busy                      VGA controller cannot take a write
//   select, bus_w, bus_addr, bus_data  back-end bus write
//   fifo_full                     write queue full
//   bad_addr                      sticky: an undecodable write was dropped
module bepu_bus_scheduler
  import bepu_bus_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DEV_LSB    = DEV_LSB_DEFAULT,
  parameter int unsigned NUM_DEV    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data,
  output logic        m1_ready,
  input  logic        vga_busy,
  output logic [31:0] select,
  output logic        bus_w,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        fifo_full,
  output logic        bad_addr
);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;  // 1: m1 has priority on the next contention
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_data_q, bus_data_d;
  logic [31:0] sel_q, sel_d;
  logic        bad_q, bad_d;

  logic        push, pop, empty, load;
  logic [63:0] wdata, rdata;
  logic [31:0] head_addr, head_data;
  logic [3:0]  dev_idx;
  logic        idx_bad, idx_vga;

  // Arbitration: ready is combinational and means "pushed at this edge".
  always_comb begin
    m0_ready = !fifo_full && m0_valid && (!m1_valid || !rr_q);
    m1_ready = !fifo_full && m1_valid && !m0_ready;
    push     = m0_ready || m1_ready;
    wdata    = m0_ready ? {m0_addr, m0_data} : {m1_addr, m1_data};
    rr_d     = rr_q;
    if (m0_ready) begin
      rr_d = 1'b1;
    end else if (m1_ready) begin
      rr_d = 1'b0;
    end
  end

  bepu_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (empty)
  );

  always_comb begin
    head_addr = rdata[63:32];
    head_data = rdata[31:0];
    dev_idx   = head_addr[DEV_LSB +: 4];
    idx_bad   = (32'(dev_idx) >= NUM_DEV);
    idx_vga   = (dev_idx == 4'(DEV_VGA));
  end

  // Issue FSM; select is only non-zero during the ISSUE cycle.
  always_comb begin
    state_d    = state_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    sel_d      = '0;
    bad_d      = bad_q;
    pop        = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          if (idx_bad) begin
            pop   = 1'b1;
            bad_d = 1'b1;
          end else if (idx_vga && vga_busy) begin
            state_d = StWaitVga;
          end else begin
            load = 1'b1;
          end
        end
      end
      StIssue:   state_d = StIdle;
      StWaitVga: load = !vga_busy;
      default:   state_d = StIdle;
    endcase
    if (load) begin
      pop        = 1'b1;
      bus_addr_d = head_addr;
      bus_data_d = head_data;
      sel_d      = 32'd1 << dev_idx;
      state_d    = StIssue;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      sel_q      <= '0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      sel_q      <= sel_d;
      bad_q      <= bad_d;
    end
  end

  always_comb begin
    bus_w    = (state_q == StIssue);
    select   = sel_q;
    bus_addr = bus_addr_q;
    bus_data = bus_data_q;
    bad_addr = bad_q;
  end

endmodule

// File: doc/bepu_bus_scheduler.md
Name: bepu_bus_scheduler

Overview:
- Sits between the front-end processing unit and the back-end peripheral unit.
- Accepts peripheral write requests from two masters: m0 is the CPU store path and m1 is the debug/boot loader. A round-robin arbiter grants one master at a time, and accepted writes are queued in a small FIFO.
- Each queued write is issued onto the back-end bus as a one-cycle write strobe, with a one-hot select decoded from the address.
- Writes to the VGA region are held off while the VGA controller reports it is busy.

Parameters:
- FIFO_DEPTH, 4, number of queued writes; must be a power of 2 and at least 2.
- DEV_LSB, 12, lowest address bit of the 4-bit device index field addr[DEV_LSB+3:DEV_LSB].
- NUM_DEV, 3, number of valid device indices: 0 = LED, 1 = segment, 2 = VGA.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- m0_valid  in  1  master 0 write request.
- m0_addr  in  32  master 0 address.
- m0_data  in  32  master 0 write data.
- m0_ready  out  1  master 0 request accepted this cycle.
- m1_valid  in  1  master 1 write request.
- m1_addr  in  32  master 1 address.
- m1_data  in  32  master 1 write data.
- m1_ready  out  1  master 1 request accepted this cycle.
- vga_busy  in  1  VGA controller cannot accept a write (active display period).
- select  out  32  one-hot device select; bit[idx] = device index.
- bus_w  out  1  one-cycle write strobe to the back-end bus.
- bus_addr  out  32  address of the write being issued.
- bus_data  out  32  data of the write being issued.
- fifo_full  out  1  status flag: FIFO is full.
- bad_addr  out  1  sticky flag: an undecodable write was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - select=0, bus_w=0, bus_addr=0, bus_data=0, m0_ready=0, m1_ready=0.
  - FIFO empty, fifo_full=0, bad_addr=0.
  - Round-robin pointer set to favour m0; FSM in IDLE.
- Arbitration (combinational ready):
  - A master may be granted only when the FIFO is not full.
  - If only one master has valid=1, that master is granted.
  - If both have valid=1, the master not granted most recently wins. The pointer updates only on a grant.
  - mX_ready=1 means the request is pushed into the FIFO at this clock edge. At most one push per cycle.
  - A master holds addr, data and valid until it sees ready.
- FIFO:
  - Each entry is {addr, data}, and the FIFO holds up to FIFO_DEPTH entries.
  - Read and write pointers are one bit wider than the index, and wrap modulo 2*FIFO_DEPTH.
  - Full: the index bits are equal and the MSBs differ. Empty: the pointers are equal.
  - A push and a pop in the same cycle are allowed when the FIFO is full; the count is unchanged. Even so, ready is deasserted while the FIFO is full, so this case only occurs when the pop was already committed.
- FSM (states IDLE, ISSUE, WAIT_VGA):
  - IDLE: when the FIFO is not empty, decode the head entry's index field idx.
    - idx >= NUM_DEV: pop the entry, set bad_addr (sticky until reset), and stay in IDLE. No strobe is issued.
    - idx == 2 and vga_busy=1: go to WAIT_VGA. No pop.
    - Otherwise: register bus_addr, bus_data and select = 1<<idx, pop the entry, and go to ISSUE.
  - ISSUE: bus_w=1 for exactly one cycle. select, addr and data stay valid in the same cycle. Go to IDLE.
  - WAIT_VGA: stay while vga_busy=1. When vga_busy=0, register and pop exactly as in IDLE, then go to ISSUE.
  - Outside ISSUE, bus_w=0 and select=0. bus_addr and bus_data hold their last values.
- Latency: a request accepted at edge N is registered at edge N+1 (empty FIFO, non-VGA or VGA idle), and bus_w=1 in cycle N+1..N+2.
- Throughput: one write per 2 cycles. Writes are issued strictly in acceptance order.
- A VGA write stuck in WAIT_VGA blocks all later writes (head-of-line blocking; order is preserved).
- Reset mid-operation: all queued writes are discarded and any strobe in progress ends immediately.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ISSUE, WAIT_VGA),
  - device index constants DEV_LED=0, DEV_SEG=1, DEV_VGA=2,
  - the default DEV_LSB.
- Natural sub-module: bepu_write_fifo, a parameterised synchronous FIFO with push, pop, full and empty, using the same clk and rst.

Test Plan:
- Single write: m0 writes addr 0x0000_0000, data 0xA5 -> m0_ready=1 for 1 cycle; 2 cycles later bus_w=1 for 1 cycle with select=0x1, bus_data=0xA5.
- Round-robin: m0 and m1 both held valid (m0 addr 0x1000 data 1; m1 addr 0x1000 data 2) -> grants alternate m0, m1, m0…; bus_data sequence 1, 2, 1, 2; select=0x2 on every strobe.
- Full FIFO: hold vga_busy=1 and push 5 VGA writes (addr 0x2000) -> 4 are accepted, fifo_full=1, and the 5th sees ready=0. Release vga_busy -> 4 strobes with select=0x4 in order; the 5th is accepted once space frees.
- VGA stall: queue VGA write then LED write with vga_busy=1 for 10 cycles -> no bus_w during the stall. After release, the VGA strobe occurs first, then the LED strobe.
- Bad address: write to 0x5000 -> no bus_w; bad_addr=1 and stays 1; the next valid write is still issued normally.
- Async reset: assert rst=0 mid-WAIT_VGA with 3 entries queued -> outputs clear immediately without a clock. After release, the FIFO is empty and no strobes occur.
